load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256: number of 32-bit words in the attached data memory.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk in, rst in; reset is active when rst=0.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: pipeline presents a memory request.
REQ-006 SHALL have port req_ready, output, 1 bit: unit can accept a request.
REQ-007 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port req_unsigned, input, 1 bit: zero-extend sub-word loads when 1.
REQ-010 SHALL have port req_addr, input, 32 bits: byte address.
REQ-011 SHALL have port req_wdata, input, 32 bits: store data, right-aligned for sub-word stores.
REQ-012 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata, output, 32 bits: formatted load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err, output, 1 bit: request rejected (misaligned, illegal size, out of range).
REQ-015 SHALL have port mem_addr, output, 32 bits: word index, {2'b00, addr[31:2]}.
REQ-016 SHALL have port mem_read, output, 1 bit: memory read strobe; memory data returns on mem_rdata one cycle later.
REQ-017 SHALL have port mem_write, output, 1 bit: memory write strobe; the whole word is written.
REQ-018 SHALL have port mem_wdata, output, 32 bits: word to write.
REQ-019 SHALL have port mem_rdata, input, 32 bits: registered read data from memory.

Function
REQ-020 SHALL implement FSM states IDLE, RD, CAP, WR, RESP; req_ready=1 only in IDLE.
REQ-021 SHALL accept a request on a rising edge when req_valid=1 and req_ready=1, capturing all req_* fields; later changes to req_* SHALL be ignored.
REQ-022 SHALL flag an error for: req_size=11; half with addr[0]=1; word with addr[1:0]!=0; or addr[31:2]>=MEM_WORDS.
REQ-023 On error: IDLE->RESP; SHALL assert no mem_read/mem_write; resp_err=1, resp_rdata=0.
REQ-024 Load: IDLE->RD (mem_read=1) ->CAP (mem_rdata valid, data formatted into a register) ->RESP; resp_valid 3 cycles after the accepting edge.
REQ-025 Word store: IDLE->WR (mem_write=1, mem_wdata=req_wdata) ->RESP.
REQ-026 Sub-word store: IDLE->RD->CAP (old word merged with new lane) ->WR->RESP; read-modify-write, unaffected lanes preserved.
REQ-027 Lane order SHALL be little-endian: byte lane n = bits 8n+7:8n, n=addr[1:0]; half lane = addr[1].
REQ-028 Sub-word loads SHALL sign-extend from bit 7/15 unless req_unsigned=1; req_unsigned SHALL be ignored for word loads.
REQ-029 resp_valid SHALL be high exactly one cycle (RESP); RESP->IDLE unconditionally.
REQ-030 mem_read and mem_write SHALL never be high together and SHALL be 0 outside RD/WR; mem_addr holds its last value otherwise.
REQ-031 resp_rdata and resp_err SHALL hold their values until the next RESP.

Reset
REQ-032 rst=0 SHALL immediately force IDLE, req_ready=1 (after release), resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-033 Reset mid-operation SHALL discard the pending request: no response, no memory write issued.

Structure
REQ-034 Package lsu_pkg SHALL hold size encodings, the FSM state enum and the MEM_WORDS default.
REQ-035 A combinational sub-module lsu_lane_format SHALL perform load extract/extend and store merge.

Verification
REQ-036 Store word 0xDEADBEEF at 0x80, then load word at 0x80 -> resp_rdata=0xDEADBEEF, resp_err=0.
REQ-037 After REQ-036: byte load at 0x83 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; signed half at 0x82 -> 0xFFFFDEAD.
REQ-038 Store byte 0x55 at 0x81 -> exactly one mem_read then one mem_write; word load at 0x80 -> 0xDEAD55EF.
REQ-039 Word load at 0x06 and word load at 0x400 (MEM_WORDS=256) -> resp_err=1, resp_rdata=0; mem_read and mem_write stay 0.
REQ-040 rst=0 during WR of a word store to 0x84 -> mem_write drops immediately, no resp_valid; word load at 0x84 after release returns the original value.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states
// and the default data-memory depth.
package lsu_pkg;

    localparam int MEM_WORDS_DEFAULT = 256;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_RESP
    } lsu_state_e;

    // Bytes can sit on any lane; halves need an even address, words a multiple of four.
    function automatic logic addr_misaligned(input lsu_size_e size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = (offset != 2'b00);
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_format.sv
// Little-endian lane handling: extracts and extends sub-word load data, and
// merges sub-word store data into the old memory word.
module lsu_lane_format
    import lsu_pkg::*;
(
    input  lsu_size_e   size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_word_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v        = old_word_i[{offset_i, 3'b000} +: 8];
        half_v        = offset_i[1] ? old_word_i[31:16] : old_word_i[15:0];
        load_data_o   = 32'h0;
        merged_word_o = old_word_i;
        case (size_i)
            SIZE_BYTE: begin
                load_data_o = unsigned_i ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
                merged_word_o[{offset_i, 3'b000} +: 8] = store_data_i[7:0];
            end
            SIZE_HALF: begin
                load_data_o = unsigned_i ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
                if (offset_i[1]) begin
                    merged_word_o[31:16] = store_data_i[15:0];
                end else begin
                    merged_word_o[15:0] = store_data_i[15:0];
                end
            end
            SIZE_WORD: begin
                load_data_o   = old_word_i;
                merged_word_o = store_data_i;
            end
            default: begin
                load_data_o   = 32'h0;
                merged_word_o = old_word_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit in front of a word-wide data memory with a
// one-cycle registered read; sub-word stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q;
    logic        write_q;
    lsu_size_e   size_q;
    logic        unsigned_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    lsu_size_e   req_size_d;
    logic        req_err_d;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign req_size_d = lsu_size_e'(req_size);
    assign req_err_d  = (req_size_d == SIZE_ILLEGAL)
                     || addr_misaligned(req_size_d, req_addr[1:0])
                     || ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

    lsu_lane_format u_lane_format (
        .size_i       (size_q),
        .unsigned_i   (unsigned_q),
        .offset_i     (offset_q),
        .old_word_i   (mem_rdata),
        .store_data_i (wdata_q),
        .load_data_o  (load_data),
        .merged_word_o(merged_word)
    );

    // Rejected requests jump straight to RESP without touching memory; only
    // sub-word stores need the read phase before writing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            size_q       <= SIZE_BYTE;
            unsigned_q   <= 1'b0;
            offset_q     <= 2'b00;
            wdata_q      <= 32'h0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q    <= req_write;
                        size_q     <= req_size_d;
                        unsigned_q <= req_unsigned;
                        offset_q   <= req_addr[1:0];
                        wdata_q    <= req_wdata;
                        if (req_err_d) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else begin
                            mem_addr_q <= {2'b00, req_addr[31:2]};
                            if (req_write && (req_size_d == SIZE_WORD)) begin
                                state_q     <= ST_WR;
                                mem_write_q <= 1'b1;
                                mem_wdata_q <= req_wdata;
                            end else begin
                                state_q    <= ST_RD;
                                mem_read_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_RD: begin
                    mem_read_q <= 1'b0;
                    state_q    <= ST_CAP;
                end
                ST_CAP: begin
                    if (write_q) begin
                        state_q     <= ST_WR;
                        mem_write_q <= 1'b1;
                        mem_wdata_q <= merged_word;
                    end else begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= load_data;
                    end
                end
                ST_WR: begin
                    state_q      <= ST_RESP;
                    mem_write_q  <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0;
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 256-word registered-read memory
// model; every word starts as 0xC0DE0000 | index.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;
    int readCount = 0;
    int writeCount = 0;
    int overlap = 0;

    logic [31:0] respData;
    logic        respErr;
    int          respLat;
    logic        respWidth;

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_addr    (mem_addr),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'hC0DE_0000 | i;
        end
    end

    always @(posedge clk) begin
        if (mem_read && mem_addr < 256) begin
            mem_rdata <= mem[mem_addr[7:0]];
        end
        if (mem_write && mem_addr < 256) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (mem_read) readCount++;
        if (mem_write) writeCount++;
        if (mem_read && mem_write) overlap++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one request, then scramble req_* to prove the unit captured them.
    task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        readCount  = 0;
        writeCount = 0;
        respLat    = 0;
        respData   = 32'hX;
        respErr    = 1'bX;
        respWidth  = 1'b0;
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_write    = ~w;
        req_size     = 2'b11;
        req_unsigned = ~uns;
        req_addr     = 32'hFFFF_FFFF;
        req_wdata    = 32'h0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                respLat  = c;
                respData = resp_rdata;
                respErr  = resp_err;
                break;
            end
        end
        @(negedge clk);
        respWidth = resp_valid;
    endtask

    initial begin
        $display("[TB] load_store_unit directed test");
        #12;
        @(negedge clk);
        checkOutput("rst_ready",      32'(req_ready),  32'd1);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_err",   32'(resp_err),   32'd0);
        checkOutput("rst_resp_rdata", resp_rdata,      32'h0);
        checkOutput("rst_mem_read",   32'(mem_read),   32'd0);
        checkOutput("rst_mem_write",  32'(mem_write),  32'd0);
        checkOutput("rst_mem_addr",   mem_addr,        32'h0);
        checkOutput("rst_mem_wdata",  mem_wdata,       32'h0);
        rst = 1'b1;

        applyStimulus(1'b1, 2'b10, 1'b0, 32'h80, 32'hDEAD_BEEF);
        checkOutput("sw_lat",    32'(respLat),    32'd2);
        checkOutput("sw_err",    32'(respErr),    32'd0);
        checkOutput("sw_rdata",  respData,        32'h0);
        checkOutput("sw_reads",  32'(readCount),  32'd0);
        checkOutput("sw_writes", 32'(writeCount), 32'd1);
        checkOutput("sw_mem",    mem[32],         32'hDEAD_BEEF);

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
        checkOutput("lw_lat",    32'(respLat),   32'd3);
        checkOutput("lw_data",   respData,       32'hDEAD_BEEF);
        checkOutput("lw_err",    32'(respErr),   32'd0);
        checkOutput("lw_reads",  32'(readCount), 32'd1);
        checkOutput("lw_pulse",  32'(respWidth), 32'd0);
        checkOutput("lw_hold",   resp_rdata,     32'hDEAD_BEEF);
        checkOutput("ready_idle", 32'(req_ready), 32'd1);

        applyStimulus(1'b0, 2'b00, 1'b0, 32'h83, 32'h0);
        checkOutput("lb_83",  respData, 32'hFFFF_FFDE);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h83, 32'h0);
        checkOutput("lbu_83", respData, 32'h0000_00DE);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h82, 32'h0);
        checkOutput("lh_82",  respData, 32'hFFFF_DEAD);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h80, 32'h0);
        checkOutput("lhu_80", respData, 32'h0000_BEEF);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h81, 32'h0);
        checkOutput("lb_81",  respData, 32'hFFFF_FFBE);
        applyStimulus(1'b0, 2'b10, 1'b1, 32'h80, 32'h0);
        checkOutput("lw_uns", respData, 32'hDEAD_BEEF);

        applyStimulus(1'b1, 2'b00, 1'b0, 32'h81, 32'hFFFF_FF55);
        checkOutput("sb_lat",    32'(respLat),    32'd4);
        checkOutput("sb_reads",  32'(readCount),  32'd1);
        checkOutput("sb_writes", 32'(writeCount), 32'd1);
        checkOutput("sb_err",    32'(respErr),    32'd0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
        checkOutput("sb_readback", respData, 32'hDEAD_55EF);

        applyStimulus(1'b1, 2'b01, 1'b0, 32'h82, 32'hFFFF_1234);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
        checkOutput("sh_readback", respData, 32'h1234_55EF);

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
        checkOutput("mis_err",    32'(respErr),    32'd1);
        checkOutput("mis_rdata",  respData,        32'h0);
        checkOutput("mis_lat",    32'(respLat),    32'd1);
        checkOutput("mis_mem",    32'(readCount + writeCount), 32'd0);
        checkOutput("err_addr_hold", mem_addr,     32'h20);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        checkOutput("oor_err",   32'(respErr),    32'd1);
        checkOutput("oor_rdata", respData,        32'h0);
        checkOutput("oor_mem",   32'(readCount + writeCount), 32'd0);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        checkOutput("ill_err",   32'(respErr),    32'd1);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h85, 32'hAAAA);
        checkOutput("sh_mis_err",    32'(respErr),    32'd1);
        checkOutput("sh_mis_writes", 32'(writeCount), 32'd0);
        checkOutput("last_in_range", mem[255], 32'hC0DE_00FF);

        @(negedge clk);
        readCount  = 0;
        writeCount = 0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h84;
        req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("wr_strobe", 32'(mem_write), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rst_drop_write", 32'(mem_write), 32'd0);
        respWidth = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (resp_valid) respWidth = 1'b1;
        end
        checkOutput("rst_no_resp", 32'(respWidth), 32'd0);
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (resp_valid) respWidth = 1'b1;
        end
        checkOutput("rst_no_resp_after", 32'(respWidth), 32'd0);
        checkOutput("rst_no_write", 32'(writeCount), 32'd0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h84, 32'h0);
        checkOutput("rst_readback", respData, 32'hC0DE_0021);
        checkOutput("no_overlap", 32'(overlap), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
